pe_array_id_loader: RTL and testbench

//  Sequencer that loads the PE-array multicast IDs into the PEs' ID registers before a layer runs.
//  It walks the X/Y IDs and the LN_config word produced by the combinational ID generator and

---
 rtl/pe_array_id_loader.sv | 185 ++++++++++++++++++
 tb/tb_pe_array_id_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_id_loader.sv
// Walks the multicast X/Y IDs and the LN_config word for all four config buses and
// streams them to the PE array one beat per valid/ready handshake.
module pe_array_id_loader #(
    parameter int NUM_ROWS = 6,
    parameter int NUM_COLS = 8,
    parameter int XID_W    = 5,
    parameter int YID_W    = 3,
    parameter int LN_W     = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [2:0]                           pe_h,
    input  logic [3:0]                           pe_w,
    input  logic [4*NUM_ROWS*NUM_COLS*XID_W-1:0] xid_flat,
    input  logic [4*NUM_ROWS*YID_W-1:0]          yid_flat,
    input  logic [LN_W-1:0]                      ln_config,
    output logic                                 cfg_valid,
    input  logic                                 cfg_ready,
    output logic [1:0]                           cfg_bus,
    output logic [1:0]                           cfg_kind,
    output logic [2:0]                           cfg_row,
    output logic [3:0]                           cfg_col,
    output logic [5:0]                           cfg_idx,
    output logic [4:0]                           cfg_data,
    output logic                                 busy,
    output logic                                 done
);

    localparam int NPE    = NUM_ROWS * NUM_COLS;
    localparam int DATA_W = 5;
    localparam int XO_W   = $clog2(4 * NPE * XID_W);
    localparam int YO_W   = $clog2(4 * NUM_ROWS * YID_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_Y,
        S_LOAD_X,
        S_LN,
        S_DONE
    } state_t;

    state_t      state, state_n;
    logic [1:0]  bus, bus_n;
    logic [2:0]  row, row_n;
    logic [3:0]  col, col_n;
    logic [2:0]  snap_h, snap_h_n;
    logic [3:0]  snap_w, snap_w_n;

    logic [2:0]  h_clamp;
    logic [3:0]  w_clamp;
    logic [5:0]  idx;
    logic [XO_W-1:0] xoff;
    logic [YO_W-1:0] yoff;

    assign h_clamp = (pe_h > 3'(NUM_ROWS)) ? 3'(NUM_ROWS) : pe_h;
    assign w_clamp = (pe_w > 4'(NUM_COLS)) ? 4'(NUM_COLS) : pe_w;
    assign idx     = 6'(row) * 6'(snap_w) + 6'(col);
    assign xoff    = XO_W'((32'(bus) * NPE + 32'(idx)) * XID_W);
    assign yoff    = YO_W'((32'(bus) * NUM_ROWS + 32'(row)) * YID_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            bus    <= '0;
            row    <= '0;
            col    <= '0;
            snap_h <= '0;
            snap_w <= '0;
        end else begin
            state  <= state_n;
            bus    <= bus_n;
            row    <= row_n;
            col    <= col_n;
            snap_h <= snap_h_n;
            snap_w <= snap_w_n;
        end
    end

    always_comb begin
        state_n   = state;
        bus_n     = bus;
        row_n     = row;
        col_n     = col;
        snap_h_n  = snap_h;
        snap_w_n  = snap_w;
        cfg_valid = 1'b0;
        cfg_bus   = '0;
        cfg_kind  = '0;
        cfg_row   = '0;
        cfg_col   = '0;
        cfg_idx   = '0;
        cfg_data  = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    snap_h_n = h_clamp;
                    snap_w_n = w_clamp;
                    bus_n    = '0;
                    row_n    = '0;
                    col_n    = '0;
                    state_n  = (h_clamp == '0) ? S_LN : S_LOAD_Y;
                end
            end
            S_LOAD_Y: begin
                cfg_valid = 1'b1;
                busy      = 1'b1;
                cfg_bus   = bus;
                cfg_kind  = 2'd0;
                cfg_row   = row;
                cfg_data  = DATA_W'(yid_flat[yoff +: YID_W]);
                if (cfg_ready) begin
                    if (row >= snap_h - 3'd1) begin
                        row_n = '0;
                        col_n = '0;
                        if (snap_w != '0) begin
                            state_n = S_LOAD_X;
                        end else if (bus == 2'd3) begin
                            state_n = S_LN;
                        end else begin
                            bus_n   = bus + 2'd1;
                            state_n = S_LOAD_Y;
                        end
                    end else begin
                        row_n = row + 3'd1;
                    end
                end
            end
            S_LOAD_X: begin
                cfg_valid = 1'b1;
                busy      = 1'b1;
                cfg_bus   = bus;
                cfg_kind  = 2'd1;
                cfg_row   = row;
                cfg_col   = col;
                cfg_idx   = idx;
                cfg_data  = DATA_W'(xid_flat[xoff +: XID_W]);
                if (cfg_ready) begin
                    // Compare with >= so a stray counter can never index past the snapshot.
                    if (col >= snap_w - 4'd1) begin
                        col_n = '0;
                        if (row >= snap_h - 3'd1) begin
                            row_n = '0;
                            if (bus == 2'd3) begin
                                state_n = S_LN;
                            end else begin
                                bus_n   = bus + 2'd1;
                                state_n = S_LOAD_Y;
                            end
                        end else begin
                            row_n = row + 3'd1;
                        end
                    end else begin
                        col_n = col + 4'd1;
                    end
                end
            end
            S_LN: begin
                cfg_valid = 1'b1;
                busy      = 1'b1;
                cfg_kind  = 2'd2;
                cfg_data  = DATA_W'(ln_config);
                if (cfg_ready) state_n = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Abort drops the presented beat even if ready is high this cycle.
        if (abort && (state == S_LOAD_Y || state == S_LOAD_X || state == S_LN)) begin
            state_n = S_IDLE;
            bus_n   = '0;
            row_n   = '0;
            col_n   = '0;
        end
    end

endmodule

// File: tb/tb_pe_array_id_loader.sv
// Directed + randomized bench for pe_array_id_loader against a loop-based beat-list model.
module tb_pe_array_id_loader;

    localparam int NUM_ROWS = 6;
    localparam int NUM_COLS = 8;
    localparam int XID_W    = 5;
    localparam int YID_W    = 3;
    localparam int LN_W     = 5;

    typedef struct packed {
        logic [1:0] bus;
        logic [1:0] kind;
        logic [2:0] row;
        logic [3:0] col;
        logic [5:0] idx;
        logic [4:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst, start, abort, cfg_ready;
    logic [2:0] pe_h;
    logic [3:0] pe_w;
    logic [4*NUM_ROWS*NUM_COLS*XID_W-1:0] xid_flat;
    logic [4*NUM_ROWS*YID_W-1:0] yid_flat;
    logic [LN_W-1:0] ln_config;
    logic cfg_valid, busy, done;
    logic [1:0] cfg_bus, cfg_kind;
    logic [2:0] cfg_row;
    logic [3:0] cfg_col;
    logic [5:0] cfg_idx;
    logic [4:0] cfg_data;

    int checks = 0;
    int errors = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    pe_array_id_loader #(
        .NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS), .XID_W(XID_W), .YID_W(YID_W), .LN_W(LN_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pe_h(pe_h), .pe_w(pe_w),
        .xid_flat(xid_flat), .yid_flat(yid_flat), .ln_config(ln_config),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_bus(cfg_bus), .cfg_kind(cfg_kind), .cfg_row(cfg_row), .cfg_col(cfg_col),
        .cfg_idx(cfg_idx), .cfg_data(cfg_data), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t cur_beat();
        return {cfg_bus, cfg_kind, cfg_row, cfg_col, cfg_idx, cfg_data};
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({cfg_valid, cfg_bus, cfg_kind, cfg_row, cfg_col, cfg_idx, cfg_data, busy, done});
    endfunction

    task automatic rand_data();
        for (int i = 0; i < 4 * NUM_ROWS * NUM_COLS; i++) xid_flat[i*XID_W +: XID_W] = XID_W'($urandom);
        for (int i = 0; i < 4 * NUM_ROWS; i++) yid_flat[i*YID_W +: YID_W] = YID_W'($urandom);
        ln_config = LN_W'($urandom);
    endtask

    // Expected beat list straight from the loading order: per bus, all YIDs then all XIDs row-major.
    task automatic build_model(input int h_in, input int w_in);
        int h, w;
        h = (h_in > NUM_ROWS) ? NUM_ROWS : h_in;
        w = (w_in > NUM_COLS) ? NUM_COLS : w_in;
        exp_q.delete();
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < h; r++)
                exp_q.push_back({2'(b), 2'd0, 3'(r), 4'd0, 6'd0,
                                 5'(yid_flat[(b*NUM_ROWS + r)*YID_W +: YID_W])});
            for (int r = 0; r < h; r++)
                for (int c = 0; c < w; c++)
                    exp_q.push_back({2'(b), 2'd1, 3'(r), 4'(c), 6'(r*w + c),
                                     5'(xid_flat[(b*NUM_ROWS*NUM_COLS + r*w + c)*XID_W +: XID_W])});
        end
        exp_q.push_back({2'd0, 2'd2, 3'd0, 4'd0, 6'd0, 5'(ln_config)});
    endtask

    // mode 0: always ready, 1: ready low 3 cycles at beat 10, 2: random ready
    task automatic run_load(input int h, input int w, input int mode, input int restart_at,
                            input bit poke_done);
        int n, cyc, done_cyc, last_acc, stalls;
        bit prev_stall;
        beat_t prev;
        build_model(h, w);
        pe_h = 3'(h); pe_w = 4'(w); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; cyc = 1; done_cyc = -1; last_acc = -1; stalls = 0; prev_stall = 1'b0; prev = '0;
        while (cyc < 3000) begin
            if (done) begin
                done_cyc = cyc;
                chk("done_idle", {30'd0, cfg_valid, busy}, 0);
                if (poke_done) begin
                    start = 1'b1; pe_h = 3'd6; pe_w = 4'd8;
                end
                break;
            end
            chk("valid_busy", {30'd0, cfg_valid, busy}, 32'd3);
            if (prev_stall) chk("hold", 32'(cur_beat()), 32'(prev));
            case (mode)
                0: cfg_ready = 1'b1;
                1: cfg_ready = !(n == 10 && stalls < 3);
                default: cfg_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (cfg_valid && !cfg_ready) stalls++;
            if (cyc == restart_at) begin
                start = 1'b1; pe_h = 3'($urandom_range(1, 7)); pe_w = 4'($urandom_range(0, 15));
            end
            if (cfg_valid && cfg_ready) begin
                if (n < exp_q.size()) chk("beat", 32'(cur_beat()), 32'(exp_q[n]));
                else chk("extra_beat", 32'(n), 32'(exp_q.size() - 1));
                n++;
                last_acc = cyc;
            end
            prev = cur_beat();
            prev_stall = cfg_valid && !cfg_ready;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk("beat_count", 32'(n), 32'(exp_q.size()));
        chk("done_lat", 32'(done_cyc), 32'(last_acc + 1));
        if (mode == 0) chk("done_cyc", 32'(done_cyc), 32'(exp_q.size() + 1));
        @(posedge clk); #1;
        start = 1'b0;
        chk("after_done", all_outs(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_ready = 1'b0;
        pe_h = '0; pe_w = '0; xid_flat = '0; yid_flat = '0; ln_config = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", all_outs(), 0);
        start = 1'b1; pe_h = 3'd6; pe_w = 4'd8;
        @(posedge clk); #1;
        chk("reset_wins", all_outs(), 0);
        rst = 1'b0; start = 1'b0;

        rand_data();
        run_load(6, 8, 0, -1, 1'b1);           // full load, start in DONE ignored
        rand_data();
        run_load(6, 8, 1, -1, 1'b0);           // 3-cycle stall at beat 10
        rand_data();
        run_load(2, 3, 0, -1, 1'b0);           // 33 beats
        chk("model_2x3", 32'(exp_q.size()), 32'd33);
        rand_data();
        ln_config = 5'd27;
        run_load(0, 5, 0, -1, 1'b0);           // LN beat only
        chk("ln_only", 32'(exp_q[0].data), 32'd27);
        rand_data();
        run_load(6, 8, 2, 30, 1'b0);           // second start mid-load ignored

        // abort with ready high at beat 50: beat dropped, no done
        rand_data();
        pe_h = 3'd6; pe_w = 4'd8; cfg_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int n = 0;
            for (int i = 0; i < 100 && n < 50; i++) begin
                if (cfg_valid && cfg_ready) n++;
                @(posedge clk); #1;
            end
            chk("abort_pre_valid", {31'd0, cfg_valid}, 1);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", {29'd0, cfg_valid, busy, done}, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", {29'd0, cfg_valid, busy, done}, 0);
        end
        run_load(6, 8, 0, -1, 1'b0);

        // start and abort together from IDLE
        start = 1'b1; abort = 1'b1; pe_h = 3'd3; pe_w = 4'd2;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", all_outs(), 0);

        // reset in the middle of LOAD_X
        rand_data();
        pe_h = 3'd6; pe_w = 4'd8; cfg_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        chk("mid_x_kind", 32'(cfg_kind), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_outs", all_outs(), 0);
        run_load(6, 8, 0, -1, 1'b0);

        // randomized sizes (including values that need clamping) with random ready
        for (int t = 0; t < 6; t++) begin
            rand_data();
            run_load($urandom_range(0, 7), $urandom_range(0, 15), 2, -1, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
